instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter WIDTH, 16, instruction word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, 16, number of instruction words; SHALL be 2 or more.
REQ-003 Parameter PC_W, 16, program-counter width in bits.
REQ-004 Parameter NOP, all-zero WIDTH-bit value, instruction word returned on an error response.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ld_en  input  1  program-load write strobe.
REQ-008 ld_addr  input  clog2(DEPTH)  word index to write.
REQ-009 ld_data  input  WIDTH  word to write.
REQ-010 req_valid  input  1  fetch request present.
REQ-011 req_ready  output  1  fetch request can be accepted this cycle.
REQ-012 req_pc  input  PC_W  byte address of the requested instruction.
REQ-013 resp_valid  output  1  response register holds a result.
REQ-014 resp_ready  input  1  consumer takes the response this cycle.
REQ-015 resp_instr  output  WIDTH  fetched instruction word, or NOP on error.
REQ-016 resp_err  output  1  response is an error.
REQ-017 flush  input  1  discard the held response and drop the request in the same cycle (branch redirect).
REQ-018 err_cnt  output  8  count of error responses produced, saturating.

Function
REQ-019 Memory SHALL be DEPTH x WIDTH; the array itself SHALL NOT be reset.
REQ-020 Each word SHALL have a loaded bit; the bit SHALL be set when its word is written and cleared by reset.
REQ-021 When ld_en=1, the word at ld_addr and its loaded bit SHALL be written at the clock edge; ld_addr >= DEPTH SHALL be ignored.
REQ-022 Address decode: SH = clog2(WIDTH/8); idx = req_pc >> SH.
REQ-023 A request SHALL be misaligned if req_pc[SH-1:0] != 0 (never misaligned when SH = 0).
REQ-024 Accept = req_valid & req_ready & ~flush.
REQ-025 req_ready = ~ld_en & (~resp_valid | resp_ready).
REQ-026 Loading and fetching SHALL be mutually exclusive; no request is accepted while ld_en=1.
REQ-027 Accepted request: at the next edge resp_valid=1 and resp_instr/resp_err are set (latency 1 cycle).
REQ-028 Error = misaligned, OR idx >= DEPTH, OR the loaded bit of idx is 0.
REQ-029 On error: resp_instr = NOP and resp_err = 1; otherwise resp_instr = mem[idx] and resp_err = 0.
REQ-030 While resp_valid=1 and resp_ready=0, resp_instr and resp_err SHALL hold stable.
REQ-031 Responses SHALL return in order; at most one is outstanding; with resp_ready=1 continuously, the block sustains one fetch per cycle.
REQ-032 If the response is consumed with no new accept, resp_valid SHALL fall to 0 at the next edge.
REQ-033 flush=1 SHALL clear resp_valid at the next edge, regardless of resp_ready and req_valid.
REQ-034 err_cnt SHALL increment by 1 at each edge that captures an error response, and saturate at 255.
REQ-035 A read of a word written in the same cycle cannot occur (see REQ-026); a read in a later cycle SHALL see the new data.

Reset
REQ-036 While rst=1: resp_valid=0, resp_err=0, resp_instr=NOP, err_cnt=0, all loaded bits=0.
REQ-037 req_ready SHALL follow REQ-025 with resp_valid=0, i.e. req_ready = ~ld_en.
REQ-038 Reset asserted mid-operation SHALL discard any held response immediately; memory contents persist but are unreadable until reloaded.

Verification
REQ-039 Load words 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444, then fetch pc 0, 2, 4, 6 back-to-back with resp_ready=1 -> the four words, in order, one per cycle, resp_err=0.
REQ-040 Fetch pc=3 -> resp_err=1, resp_instr=NOP, err_cnt=1; fetch pc=32 with DEPTH=16 -> error, err_cnt=2.
REQ-041 After reset, fetch pc=0 without loading -> error (unloaded word); then load word 0 = 16'hABCD and refetch -> 16'hABCD.
REQ-042 Hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable; release -> next request accepted in the same cycle.
REQ-043 Assert flush with resp_valid=1 and req_valid=1 -> resp_valid=0 next cycle, request not accepted, err_cnt unchanged.
REQ-044 Issue 300 misaligned fetches -> err_cnt reads 255; ld_en=1 during req_valid -> req_ready=0.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a program-load port and a single-entry fetch response register.
// Latency: one cycle from accepted request to resp_valid; one fetch per cycle while resp_ready=1.
// Backpressure: req_ready drops while a held response is not consumed or while a load is in progress.
module instr_fetch_mem #(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 16,
  parameter int               PC_W  = 16,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [WIDTH-1:0]         ld_data,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [PC_W-1:0]          req_pc,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_instr,
  output logic                     resp_err,
  input  logic                     flush,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SH = $clog2(WIDTH / 8);
  // Low pc bits that must be zero for an aligned fetch (empty mask for byte-wide words).
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'((1 << SH) - 1);
  localparam logic [PC_W-1:0] DEPTH_PC   = PC_W'(DEPTH);
  localparam logic [AW:0]     DEPTH_A    = (AW + 1)'(DEPTH);

  // Storage array is deliberately left without reset; the loaded bits gate readability.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_loaded;

  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_instr;
  logic             r_resp_err;
  logic [7:0]       r_err_cnt;

  logic             w_ld_ok;
  logic [PC_W-1:0]  w_idx;
  logic [AW-1:0]    w_mem_idx;
  logic             w_misal;
  logic             w_in_range;
  logic             w_err;
  logic             w_ready;
  logic             w_accept;

  // Out-of-range load addresses only exist when DEPTH is not a power of two.
  assign w_ld_ok    = ({1'b0, ld_addr} < DEPTH_A);

  assign w_idx      = req_pc >> SH;
  assign w_mem_idx  = w_idx[AW-1:0];
  assign w_misal    = (req_pc & ALIGN_MASK) != '0;
  assign w_in_range = (w_idx < DEPTH_PC);
  assign w_err      = w_misal | ~w_in_range | ~r_loaded[w_mem_idx];

  // Loads and fetches never share a cycle, so the read never races a same-cycle write.
  assign w_ready    = ~ld_en & (~r_resp_valid | resp_ready);
  assign w_accept   = req_valid & w_ready & ~flush;

  // Program-load write into the unreset storage array.
  always_ff @(posedge clk) begin
    if (ld_en && w_ld_ok) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  // Per-word loaded flags; reset makes old contents unreadable until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loaded <= '0;
    end else if (ld_en && w_ld_ok) begin
      r_loaded[ld_addr] <= 1'b1;
    end
  end

  // Response register: capture on accept, drop on consume or flush, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_instr <= NOP;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_instr <= w_err ? NOP : r_mem[w_mem_idx];
      r_resp_err   <= w_err;
    end else if (flush || resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  // Saturating count of error responses captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign req_ready  = w_ready;
  assign resp_valid = r_resp_valid;
  assign resp_instr = r_resp_instr;
  assign resp_err   = r_resp_err;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Randomised plus directed bench for instr_fetch_mem with a queue-based scoreboard.
// The driver keeps an abstract memory model and queues expected responses on accept.
// A separate monitor compares every presented response against the queue head.
module tb_instr_fetch_mem;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PC_W  = 16;
  localparam logic [WIDTH-1:0] NOP = '0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ld_en = 1'b0;
  logic [3:0]       ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [PC_W-1:0]  req_pc = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_instr;
  logic             resp_err;
  logic             flush = 1'b0;
  logic [7:0]       err_cnt;

  instr_fetch_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PC_W(PC_W), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_err(resp_err), .flush(flush), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] instr;
    logic             err;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               failures = 0;

  // Abstract model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_loaded [DEPTH];
  bit               m_valid;
  int               m_errcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus; entered and left 2 time units after a rising edge.
  task automatic drive(input logic le, input logic [3:0] la, input logic [WIDTH-1:0] ld,
                       input logic rv, input logic [PC_W-1:0] pc,
                       input logic rr, input logic fl);
    bit   mready, acc, e;
    int   widx;
    exp_t x;
    ld_en = le; ld_addr = la; ld_data = ld;
    req_valid = rv; req_pc = pc; resp_ready = rr; flush = fl;
    #1;
    mready = !le && (!m_valid || rr);
    chk("req_ready", {31'd0, req_ready}, {31'd0, mready});
    acc = rv && mready && !fl;
    if (acc) begin
      widx = int'(pc) / 2;
      if ((pc % 2) != 0)      e = 1'b1;
      else if (widx >= DEPTH) e = 1'b1;
      else                    e = !m_loaded[widx];
      x.err   = e;
      x.instr = e ? NOP : m_mem[widx];
      exp_q.push_back(x);
      if (e && m_errcnt < 255) m_errcnt++;
    end
    if (acc)            m_valid = 1'b1;
    else if (rr || fl)  m_valid = 1'b0;
    if (le && int'(la) < DEPTH) begin
      m_mem[la]    = ld;
      m_loaded[la] = 1'b1;
    end
    @(posedge clk);
    #2;
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
    chk("err_cnt", {24'd0, err_cnt}, m_errcnt);
  endtask

  task automatic fetch(input logic [PC_W-1:0] pc, input logic rr);
    drive(1'b0, 4'd0, '0, 1'b1, pc, rr, 1'b0);
  endtask

  task automatic load(input logic [3:0] a, input logic [WIDTH-1:0] d);
    drive(1'b1, a, d, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // Asserted asynchronously between edges; checks the immediate effect.
  task automatic do_reset();
    rst = 1'b1;
    ld_en = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 0);
    chk("rst_resp_instr", {16'd0, resp_instr}, {16'd0, NOP});
    chk("rst_resp_err", {31'd0, resp_err}, 0);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    exp_q.delete();
    m_valid = 1'b0;
    m_errcnt = 0;
    for (int i = 0; i < DEPTH; i++) m_loaded[i] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: compare whatever response is presented; retire it when consumed or flushed.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=valid required=none at %0t", $time);
      end else begin
        chk("resp_instr", {16'd0, resp_instr}, {16'd0, exp_q[0].instr});
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_q[0].err});
        if (resp_ready || flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    m_valid = 1'b0;
    m_errcnt = 0;
    for (int i = 0; i < DEPTH; i++) m_loaded[i] = 1'b0;
    @(posedge clk);
    #2;
    do_reset();

    // Unloaded word reads as error, then reads back after loading.
    fetch(16'd0, 1'b1);
    idle();
    load(4'd0, 16'hABCD);
    fetch(16'd0, 1'b1);
    idle();

    // Load four words and fetch them back to back.
    load(4'd0, 16'h1111);
    load(4'd1, 16'h2222);
    load(4'd2, 16'h3333);
    load(4'd3, 16'h4444);
    fetch(16'd0, 1'b1);
    fetch(16'd2, 1'b1);
    fetch(16'd4, 1'b1);
    fetch(16'd6, 1'b1);
    idle();

    // Misaligned and out-of-range fetches.
    fetch(16'd3, 1'b1);
    fetch(16'd32, 1'b1);
    idle();

    // Stall for three cycles with a pending request, then release.
    fetch(16'd2, 1'b0);
    repeat (3) fetch(16'd4, 1'b0);
    fetch(16'd4, 1'b1);
    idle();

    // Flush with a held response and a competing request.
    fetch(16'd3, 1'b0);
    drive(1'b0, 4'd0, '0, 1'b1, 16'd5, 1'b0, 1'b1);
    idle();

    // Loading blocks fetches.
    drive(1'b1, 4'd5, 16'h5555, 1'b1, 16'd10, 1'b1, 1'b0);
    fetch(16'd10, 1'b1);
    idle();

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) fetch(16'd1 + 16'(2 * (i % 8)), 1'b1);
    idle();
    chk("err_cnt_saturated", {24'd0, err_cnt}, 255);

    // Mid-operation reset with a held response.
    fetch(16'd0, 1'b0);
    do_reset();
    fetch(16'd0, 1'b1);
    idle();

    // Randomised traffic with one reset midway.
    for (int n = 0; n < 2000; n++) begin
      logic            le, rv, rr, fl;
      logic [PC_W-1:0] pc;
      if (n == 1000) do_reset();
      le = ($urandom_range(0, 99) < 20);
      rv = ($urandom_range(0, 99) < 70);
      rr = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 8);
      pc = ($urandom_range(0, 9) == 0) ? PC_W'($urandom) : PC_W'($urandom_range(0, 40));
      drive(le, 4'($urandom), WIDTH'($urandom), rv, pc, rr, fl);
    end

    idle();
    idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
